// File: rtl/mulalu_pkg.sv
// mulalu_pkg: func codes, widths and FSM state type shared by the multiply/divide unit
package mulalu_pkg;
  localparam int W_FUNC = 5;
  localparam int W_DATA = 32;
  localparam logic [W_FUNC-1:0] FUNC_MUL = 5'b00001;
  localparam logic [W_FUNC-1:0] FUNC_DIV = 5'b00010;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} mulalu_state_t;
endpackage

// File: rtl/mulalu_if.sv
// mulalu_if: EX-stage request in, stall and HI/LO write port out
interface mulalu_if import mulalu_pkg::*; ();
  logic flush;
  logic accept;
  logic [W_FUNC-1:0] func;
  logic sign;
  logic [W_DATA-1:0] source_a;
  logic [W_DATA-1:0] source_b;
  logic stall;
  logic hi_write;
  logic [W_DATA-1:0] hi_write_data;
  logic lo_write;
  logic [W_DATA-1:0] lo_write_data;
  modport master (
    output flush, accept, func, sign, source_a, source_b,
    input stall, hi_write, hi_write_data, lo_write, lo_write_data
  );
  modport slave (
    input flush, accept, func, sign, source_a, source_b,
    output stall, hi_write, hi_write_data, lo_write, lo_write_data
  );
endinterface

// File: rtl/mulalu_div_step.sv
// mulalu_div_step: one restoring-division step producing a single quotient bit
module mulalu_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              dvd_bit,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic              q_bit
);
  logic [DATA_W:0] t, diff;
  always_comb begin
    t = {rem, dvd_bit};
    diff = t - {1'b0, divisor};
    q_bit = !diff[DATA_W];
    rem_next = q_bit ? diff[DATA_W-1:0] : t[DATA_W-1:0];
  end
endmodule

// File: rtl/mulalu.sv
// mulalu: 32-cycle shift-add multiply / restoring divide feeding HI/LO; define MULALU_FAST_MUL_EN for a single-cycle multiply
module mulalu
  import mulalu_pkg::*;
#(
  parameter int DATA_W = W_DATA,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input logic clk,
  input logic rst_n,
  mulalu_if.slave bus
);
  if (DATA_W != 32) begin : g_width_check
    $error("mulalu supports only DATA_W = 32");
  end
`ifdef MULALU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
  logic [2*DATA_W-1:0] ext_a, ext_b, fast_prod;
  assign ext_a = {{DATA_W{bus.sign & bus.source_a[DATA_W-1]}}, bus.source_a};
  assign ext_b = {{DATA_W{bus.sign & bus.source_b[DATA_W-1]}}, bus.source_b};
  assign fast_prod = ext_a * ext_b;
`else
  localparam bit FAST_MUL = 1'b0;
  logic [2*DATA_W-1:0] fast_prod;
  assign fast_prod = '0;
`endif
  mulalu_state_t state, state_d;
  logic [CNT_W-1:0] cnt;
  logic [2*DATA_W-1:0] p, p_next;
  logic [DATA_W-1:0] dvs, abs_a, abs_b, q, r, hi_res, lo_res, rem_next, hi_q, lo_q;
  logic [DATA_W:0] sum;
  logic neg_a, neg_b, in_neg_a, in_neg_b, is_mul, req, busy, last, q_bit;
  assign is_mul = bus.func == FUNC_MUL;
  assign req = rst_n && !bus.flush && (is_mul || bus.func == FUNC_DIV);
  assign busy = state == MUL || state == DIV;
  assign last = cnt == CNT_W'(DATA_W - 1);
  assign in_neg_a = bus.sign & bus.source_a[DATA_W-1];
  assign in_neg_b = bus.sign & bus.source_b[DATA_W-1];
  assign abs_a = in_neg_a ? -bus.source_a : bus.source_a;
  assign abs_b = in_neg_b ? -bus.source_b : bus.source_b;
  mulalu_div_step #(.DATA_W(DATA_W)) u_div_step (
    .rem(p[2*DATA_W-1:DATA_W]),
    .dvd_bit(p[DATA_W-1]),
    .divisor(dvs),
    .rem_next(rem_next),
    .q_bit(q_bit)
  );
  // p holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    sum = {1'b0, p[2*DATA_W-1:DATA_W]} + (p[0] ? {1'b0, dvs} : '0);
    p_next = state == MUL ? {sum, p[DATA_W-1:1]} : {rem_next, p[DATA_W-2:0], q_bit};
    q = p_next[DATA_W-1:0];
    r = p_next[2*DATA_W-1:DATA_W];
    hi_res = state == MUL ? ((neg_a ^ neg_b) ? (-p_next) >> DATA_W : {32'b0, r}) : (neg_a ? -r : r);
    lo_res = state == MUL ? ((neg_a ^ neg_b) ? -q : q)
           : dvs == '0 ? '1 : ((neg_a ^ neg_b) ? -q : q);
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = !req ? IDLE : is_mul ? (FAST_MUL ? DONE : MUL) : DIV;
      MUL,
      DIV:     state_d = last ? DONE : state;
      default: state_d = bus.accept ? IDLE : DONE;
    endcase
    if (bus.flush) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      p <= '0;
      dvs <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && req) begin
        cnt <= '0;
        neg_a <= in_neg_a;
        neg_b <= in_neg_b;
        p <= {{DATA_W{1'b0}}, is_mul ? abs_b : abs_a};
        dvs <= is_mul ? abs_a : abs_b;
        if (FAST_MUL && is_mul) {hi_q, lo_q} <= fast_prod;
      end else if (busy && !bus.flush) begin
        cnt <= cnt + 1'b1;
        p <= p_next;
        if (last) {hi_q, lo_q} <= {hi_res, lo_res};
      end
    end
  end
  always_comb begin
    bus.stall = state == IDLE ? req : busy && !bus.flush;
    bus.hi_write = state == DONE && bus.accept && !bus.flush;
    bus.lo_write = bus.hi_write;
    bus.hi_write_data = hi_q;
    bus.lo_write_data = lo_q;
  end
endmodule

// File: tb/tb_mulalu.sv
// tb_mulalu: directed vectors; expected HI/LO queued at issue and checked by a strobe monitor
module tb_mulalu;
  import mulalu_pkg::*;
`ifdef MULALU_FAST_MUL_EN
  localparam int MULC = 1;
`else
  localparam int MULC = 33;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e;
  mulalu_if bus();
  mulalu dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && (bus.hi_write || bus.lo_write)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL strobe: got unexpected write hi=%h lo=%h expected none", bus.hi_write_data, bus.lo_write_data);
      end else begin
        e = exp_q.pop_front();
        chk("hi_lo", {bus.hi_write_data, bus.lo_write_data}, e);
        chk("strobe_pair", 64'({bus.hi_write, bus.lo_write}), 64'd3);
      end
    end
  end
  task automatic op(input logic [4:0] f, input logic s, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] ehi, input logic [31:0] elo, input int ecyc);
    int n;
    @(posedge clk); #1;
    bus.func = f; bus.sign = s; bus.source_a = a; bus.source_b = b; bus.accept = 1'b1;
    exp_q.push_back({ehi, elo});
    n = 0;
    @(negedge clk);
    if (bus.stall) n++;
    @(posedge clk); #1;
    bus.func = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.stall) break;
      n++;
    end
    chk("stall_cycles", 64'(n), 64'(ecyc));
    @(posedge clk); #1;
  endtask
  initial begin
    int n;
    bus.flush = 1'b0; bus.accept = 1'b0; bus.func = '0; bus.sign = 1'b0;
    bus.source_a = '0; bus.source_b = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", {29'b0, bus.stall, bus.hi_write, bus.lo_write, bus.hi_write_data}, 64'd0);
    chk("reset_lo", 64'(bus.lo_write_data), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    op(FUNC_MUL, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MULC);
    op(FUNC_MUL, 1'b1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, MULC);
    op(FUNC_MUL, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, MULC);
    op(FUNC_MUL, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, MULC);
    op(FUNC_DIV, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    op(FUNC_DIV, 1'b0, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 33);
    op(FUNC_DIV, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 33);
    op(FUNC_DIV, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33);
    op(FUNC_DIV, 1'b0, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 33);
    op(FUNC_DIV, 1'b1, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 33);
    op(FUNC_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);
    // flush in the tenth cycle of a divide
    bus.func = FUNC_DIV; bus.sign = 1'b0; bus.source_a = 32'd100; bus.source_b = 32'd3;
    @(posedge clk); #1 bus.func = '0;
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", 64'(bus.stall), 64'd0);
    @(posedge clk); #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("after_flush_stall", 64'(bus.stall), 64'd0);
    // request coincident with flush is dropped
    @(posedge clk); #1 bus.func = FUNC_MUL; bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_req_stall", 64'(bus.stall), 64'd0);
    @(posedge clk); #1 bus.func = '0; bus.flush = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.stall) n++;
    end
    chk("flush_idle_stall", 64'(n), 64'd0);
    // DONE held with accept low
    @(posedge clk); #1;
    bus.func = FUNC_DIV; bus.sign = 1'b0; bus.source_a = 32'd7; bus.source_b = 32'd2; bus.accept = 1'b0;
    @(posedge clk); #1 bus.func = '0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.stall) break;
      n++;
    end
    chk("hold_stall_cycles", 64'(n), 64'd32);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_data", {bus.hi_write_data, bus.lo_write_data}, {32'd1, 32'd3});
      chk("hold_quiet", 64'({bus.stall, bus.hi_write, bus.lo_write}), 64'd0);
    end
    @(posedge clk); #1;
    exp_q.push_back({32'd1, 32'd3});
    bus.accept = 1'b1;
    @(posedge clk); #1;
    // reset in the middle of a multiply
    bus.func = FUNC_MUL; bus.source_a = 32'd5; bus.source_b = 32'd6;
    @(posedge clk); #1 bus.func = '0;
    repeat (5) @(posedge clk);
    #1 bus.func = FUNC_MUL; rst_n = 1'b0;
    #1 chk("reset_mid_mul", {29'b0, bus.stall, bus.hi_write, bus.lo_write, bus.hi_write_data}, 64'd0);
    chk("reset_mid_lo", 64'(bus.lo_write_data), 64'd0);
    @(posedge clk); #1 bus.func = '0; rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.stall) n++;
    end
    chk("post_reset_stall", 64'(n), 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mulalu.md
Name: mulalu

Overview:
- Multi-cycle multiply/divide unit in the EX stage, directly downstream of the single-cycle ALU.
- Consumes the ALU's mulalu_func and mulalu_sign request plus both operands.
- Iterates for 32 cycles, stalling the pipeline while it runs.
- Delivers HI/LO write strobes and data, which the HI/LO register file consumes alongside the ALU's MTHI/MTLO writes.

Parameters:
- DATA_W, 32, operand width; only 32 supported, guarded by an elaboration-time check.
- CNT_W, 5, iteration counter width, equal to $clog2(DATA_W).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  exception/pipeline flush; aborts any operation.
- accept  in  1  EX stage advancing this cycle.
- func  in  W_FUNC  FUNC_MUL, FUNC_DIV, or 5'b00000 for no request.
- sign  in  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU).
- source_a  in  W_DATA  multiplicand/dividend.
- source_b  in  W_DATA  multiplier/divisor.
- stall  out  1  hold the pipeline.
- hi_write  out  1  HI write strobe.
- hi_write_data  out  W_DATA  HI value.
- lo_write  out  1  LO write strobe.
- lo_write_data  out  W_DATA  LO value.

Behaviour:
- States: IDLE, MUL, DIV, DONE.
- Reset values: state IDLE, counter 0, all data registers 0.
  - Registered outputs reset to 0.
  - stall is 0 out of reset because func is ignored only while rst_n is low.
- IDLE:
  - Request is valid when func is FUNC_MUL or FUNC_DIV and flush=0.
  - On a valid request: latch operands and sign, compute absolute values when sign=1, go to MUL or DIV.
  - stall = request valid (combinational).
- MUL: shift-add, one bit per cycle, 32 cycles. Counter runs 0..31; at 31 go to DONE.
- DIV: restoring division, one quotient bit per cycle, 32 cycles. Counter runs 0..31; at 31 go to DONE.
- stall = 1 throughout MUL and DIV, regardless of func.
- Latency: request accepted at cycle T; MUL/DIV occupies T+1..T+32; DONE at T+33. stall is high T..T+32 (33 cycles).
- Sign fix, applied on entry to DONE and registered:
  - Product negated when sign=1 and operand signs differ.
  - Quotient negated when signs differ.
  - Remainder takes the dividend's sign.
- Result mapping:
  - MUL: hi_write_data = product[63:32], lo_write_data = product[31:0].
  - DIV: lo_write_data = quotient, hi_write_data = remainder.
- DONE:
  - stall=0; data held stable.
  - hi_write = lo_write = accept (combinational, single-cycle pulse).
  - accept=1 -> IDLE. accept=0 -> stay in DONE, no strobe.
- After DONE exits, func still presented in the next cycle belongs to the next instruction and starts a new operation.
- Divide by zero: completes in the normal 33 cycles; lo = 32'hFFFFFFFF, hi = dividend unchanged, regardless of sign.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo = 32'h80000000, hi = 0.
- flush:
  - In any state, next state is IDLE; strobes forced 0 that cycle; stall=0 that cycle.
  - A request in the same cycle as flush is ignored.
- Reset asserted mid-operation: immediate return to IDLE, no write.
- Unused func codes are treated as no request.

Optional Feature:
- Macro MULALU_FAST_MUL_EN.
- Defined:
  - MUL uses a single-cycle 33x33 signed multiply (sign-extended when sign=1, zero-extended otherwise).
  - IDLE goes directly to DONE with the product; stall is high only in cycle T, DONE at T+1.
  - DIV is unchanged.
- Undefined: 32-cycle shift-add as above; no multiplier inferred.

Decomposition:
- includes package: FUNC_MUL, FUNC_DIV, W_FUNC, W_DATA (existing), plus new mulalu_state_t enum {IDLE, MUL, DIV, DONE}.
- Sub-module mulalu_div_step: combinational one-bit restoring step.
  - In: partial remainder, dividend bit, divisor.
  - Out: next remainder, quotient bit.
- Counter, sign fix and FSM stay in mulalu.

Test Plan:
1. Unsigned MUL, a=0xFFFFFFFF, b=0xFFFFFFFF, accept=1 -> stall high for 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, one-cycle strobe.
2. Signed MUL, a=0xFFFFFFFD, b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. With MULALU_FAST_MUL_EN, the same result after 1 stall cycle.
3. Signed DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Unsigned DIV 7/2 -> lo=3, hi=1.
4. DIV a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678. Signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
5. flush at T+10 of a DIV -> IDLE at T+11, stall=0, no hi/lo strobe ever. Request with flush=1 in IDLE -> not started.
6. Hold accept=0 for 3 cycles in DONE -> data stable, strobes 0, stall 0; accept=1 -> exactly one strobe. rst_n low mid-MUL -> all outputs 0 immediately.
